mc_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS32 control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a req/ready memory handshake, a wait-state timeout, and sticky exception flags.
- Sits between the instruction register, the ALU, the register file and the shared instruction/data memory port of the multi-cycle SOC datapath.
- Decode set: R-type ADD/ADDU/SUB/SUBU/AND/OR/XOR/SLT/SLTU; I-type ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU/LUI; LW/SW; LH/LHU/LB/LBU/SH/SB; BEQ/BNE; J.

---
 rtl/mc_control_unit.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS32 control unit: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// req/ready memory port, with a wait-state timeout and sticky exception flags.
module mc_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          SUB_WORD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       aluZero,
  input  logic       memReady,
  input  logic       excAck,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       memReq,
  output logic       memWrite,
  output logic       memAddrSel,
  output logic [1:0] memDataSize,
  output logic       memBitExtend,
  output logic       rfWriteEnable,
  output logic       rfWriteAddrSel,
  output logic [1:0] rfWriteDataSel,
  output logic       aluSrc,
  output logic [2:0] aluFunc,
  output logic       bitXtend,
  output logic       invOpcode,
  output logic       busError,
  output logic [2:0] state
);

  // ALU operation codes shared with the datapath ALU
  localparam logic [2:0] AluAnd  = 3'd0;
  localparam logic [2:0] AluOr   = 3'd1;
  localparam logic [2:0] AluAdd  = 3'd2;
  localparam logic [2:0] AluXor  = 3'd3;
  localparam logic [2:0] AluSltu = 3'd5;
  localparam logic [2:0] AluSub  = 3'd6;
  localparam logic [2:0] AluSlt  = 3'd7;

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StExcept = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       inv_q, inv_d;
  logic       bus_q, bus_d;

  // Instruction decode
  logic       dec_valid, is_load, is_store, is_beq, is_bne, is_jump;
  logic [2:0] dec_alu_func;
  logic       dec_alu_src, dec_bit_xtend, dec_addr_rd, dec_bit_extend;
  logic [1:0] dec_data_sel, dec_data_size;

  always_comb begin
    dec_valid      = 1'b0;
    is_load        = 1'b0;
    is_store       = 1'b0;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    is_jump        = 1'b0;
    dec_alu_func   = AluAnd;
    dec_alu_src    = 1'b0;
    dec_bit_xtend  = 1'b0;
    dec_addr_rd    = 1'b0;
    dec_bit_extend = 1'b0;
    dec_data_sel   = 2'd0;
    dec_data_size  = 2'd0;
    case (opc)
      6'h00: begin
        dec_valid   = 1'b1;
        dec_addr_rd = 1'b1;
        case (func)
          6'h20, 6'h21: dec_alu_func = AluAdd;
          6'h22, 6'h23: dec_alu_func = AluSub;
          6'h24:        dec_alu_func = AluAnd;
          6'h25:        dec_alu_func = AluOr;
          6'h26:        dec_alu_func = AluXor;
          6'h2a:        dec_alu_func = AluSlt;
          6'h2b:        dec_alu_func = AluSltu;
          default:      dec_valid    = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin
        dec_valid = 1'b1; dec_alu_src = 1'b1; dec_alu_func = AluAdd;
      end
      6'h0a: begin
        dec_valid = 1'b1; dec_alu_src = 1'b1; dec_alu_func = AluSlt;
      end
      6'h0b: begin
        dec_valid = 1'b1; dec_alu_src = 1'b1; dec_alu_func = AluSltu;
      end
      6'h0c: begin
        dec_valid = 1'b1; dec_alu_src = 1'b1; dec_bit_xtend = 1'b1; dec_alu_func = AluAnd;
      end
      6'h0d: begin
        dec_valid = 1'b1; dec_alu_src = 1'b1; dec_bit_xtend = 1'b1; dec_alu_func = AluOr;
      end
      6'h0e: begin
        dec_valid = 1'b1; dec_alu_src = 1'b1; dec_bit_xtend = 1'b1; dec_alu_func = AluXor;
      end
      6'h0f: begin
        dec_valid = 1'b1; dec_alu_src = 1'b1; dec_alu_func = AluAdd; dec_data_sel = 2'd2;
      end
      6'h23: begin
        dec_valid = 1'b1; is_load = 1'b1; dec_alu_src = 1'b1; dec_alu_func = AluAdd;
        dec_data_sel = 2'd1;
      end
      6'h2b: begin
        dec_valid = 1'b1; is_store = 1'b1; dec_alu_src = 1'b1; dec_alu_func = AluAdd;
      end
      6'h21, 6'h25, 6'h20, 6'h24: begin
        dec_valid      = SUB_WORD_EN;
        is_load        = 1'b1;
        dec_alu_src    = 1'b1;
        dec_alu_func   = AluAdd;
        dec_data_sel   = 2'd1;
        dec_data_size  = (opc == 6'h21 || opc == 6'h25) ? 2'd1 : 2'd2;
        dec_bit_extend = (opc == 6'h25 || opc == 6'h24);
      end
      6'h29, 6'h28: begin
        dec_valid     = SUB_WORD_EN;
        is_store      = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_func  = AluAdd;
        dec_data_size = (opc == 6'h29) ? 2'd1 : 2'd2;
      end
      6'h04: begin
        dec_valid = 1'b1; is_beq = 1'b1; dec_alu_func = AluSub;
      end
      6'h05: begin
        dec_valid = 1'b1; is_bne = 1'b1; dec_alu_func = AluSub;
      end
      6'h02: begin
        dec_valid = 1'b1; is_jump = 1'b1;
      end
      default: dec_valid = 1'b0;
    endcase
  end

  // Sequencer: next state, strobes and flag updates
  logic       ir_write, pc_write, mem_req, mem_write, mem_addr_sel, rf_we, dec_en;
  logic [1:0] pc_src;
  logic       timeout;

  assign timeout = (wait_q == WaitLast) && !memReady;

  always_comb begin
    state_d      = state_q;
    inv_d        = inv_q;
    bus_d        = bus_q;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    rf_we        = 1'b0;
    dec_en       = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (memReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          bus_d   = 1'b1;
          state_d = StExcept;
        end
      end
      StDecode: begin
        if (!dec_valid) begin
          inv_d   = 1'b1;
          state_d = StExcept;
        end else if (is_jump) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          state_d  = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        dec_en = 1'b1;
        if (is_beq || is_bne) begin
          pc_write = is_beq ? aluZero : !aluZero;
          pc_src   = 2'd1;
          state_d  = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dec_en       = 1'b1;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_write    = is_store;
        if (memReady) begin
          state_d = is_store ? StFetch : StWb;
        end else if (timeout) begin
          bus_d   = 1'b1;
          state_d = StExcept;
        end
      end
      StWb: begin
        dec_en  = 1'b1;
        rf_we   = 1'b1;
        state_d = StFetch;
      end
      StExcept: begin
        if (excAck) begin
          inv_d   = 1'b0;
          bus_d   = 1'b0;
          state_d = StFetch;
        end
      end
      default: begin
        inv_d   = 1'b1;
        state_d = StExcept;
      end
    endcase
  end

  // Wait counter restarts on completion and on any state change
  always_comb begin
    wait_d = 8'd0;
    if ((state_q == StFetch || state_q == StMem) && !memReady && state_d == state_q) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      wait_q  <= 8'd0;
      inv_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      inv_q   <= inv_d;
      bus_q   <= bus_d;
    end
  end

  // Everything is held at zero while reset is asserted
  always_comb begin
    irWrite        = rst_n & ir_write;
    pcWrite        = rst_n & pc_write;
    pcSrc          = rst_n ? pc_src : 2'd0;
    memReq         = rst_n & mem_req;
    memWrite       = rst_n & mem_write;
    memAddrSel     = rst_n & mem_addr_sel;
    rfWriteEnable  = rst_n & rf_we;
    memDataSize    = (rst_n && dec_en) ? dec_data_size : 2'd0;
    memBitExtend   = rst_n & dec_en & dec_bit_extend;
    rfWriteAddrSel = rst_n & dec_en & dec_addr_rd;
    rfWriteDataSel = (rst_n && dec_en) ? dec_data_sel : 2'd0;
    aluSrc         = rst_n & dec_en & dec_alu_src;
    aluFunc        = (rst_n && dec_en) ? dec_alu_func : 3'd0;
    bitXtend       = rst_n & dec_en & dec_bit_xtend;
    invOpcode      = inv_q;
    busError       = bus_q;
    state          = rst_n ? state_q : 3'd0;
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: one instance with a short timeout and sub-word ops,
// a second with sub-word ops disabled, both driven from the same inputs.
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opc, func;
  logic aluZero, memReady, excAck;

  logic       ir_a, pcw_a, mreq_a, mw_a, mas_a, mbe_a, rfwe_a, rfwa_a, asrc_a, bx_a, inv_a, bus_a;
  logic [1:0] pcs_a, mds_a, rfds_a;
  logic [2:0] af_a, st_a;

  logic       ir_b, pcw_b, mreq_b, mw_b, mas_b, mbe_b, rfwe_b, rfwa_b, asrc_b, bx_b, inv_b, bus_b;
  logic [1:0] pcs_b, mds_b, rfds_b;
  logic [2:0] af_b, st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.MEM_TIMEOUT(4), .SUB_WORD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opc(opc), .func(func), .aluZero(aluZero),
    .memReady(memReady), .excAck(excAck), .irWrite(ir_a), .pcWrite(pcw_a), .pcSrc(pcs_a),
    .memReq(mreq_a), .memWrite(mw_a), .memAddrSel(mas_a), .memDataSize(mds_a),
    .memBitExtend(mbe_a), .rfWriteEnable(rfwe_a), .rfWriteAddrSel(rfwa_a),
    .rfWriteDataSel(rfds_a), .aluSrc(asrc_a), .aluFunc(af_a), .bitXtend(bx_a),
    .invOpcode(inv_a), .busError(bus_a), .state(st_a)
  );

  mc_control_unit #(.MEM_TIMEOUT(15), .SUB_WORD_EN(1'b0)) dut_nsw (
    .clk(clk), .rst_n(rst_n), .opc(opc), .func(func), .aluZero(aluZero),
    .memReady(memReady), .excAck(excAck), .irWrite(ir_b), .pcWrite(pcw_b), .pcSrc(pcs_b),
    .memReq(mreq_b), .memWrite(mw_b), .memAddrSel(mas_b), .memDataSize(mds_b),
    .memBitExtend(mbe_b), .rfWriteEnable(rfwe_b), .rfWriteAddrSel(rfwa_b),
    .rfWriteDataSel(rfds_b), .aluSrc(asrc_b), .aluFunc(af_b), .bitXtend(bx_b),
    .invOpcode(inv_b), .busError(bus_b), .state(st_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step into the first cycle after release
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic run_branch(input string tag, input logic [5:0] op, input logic zero,
                            input logic exp_pw);
    opc = op; func = 6'h00; aluZero = zero; memReady = 1'b1;
    do_reset();
    tick();
    tick();
    chk({tag, "_state"}, 8'(st_a), 8'd2);
    chk({tag, "_pcWrite"}, 8'(pcw_a), 8'(exp_pw));
    chk({tag, "_pcSrc"}, 8'(pcs_a), 8'd1);
    chk({tag, "_aluFunc"}, 8'(af_a), 8'd6);
    tick();
    chk({tag, "_next"}, 8'(st_a), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; opc = 6'h00; func = 6'h20; aluZero = 1'b0; memReady = 1'b1; excAck = 1'b0;
    #12;
    chk("rst_memReq", 8'(mreq_a), 8'd0);
    chk("rst_state", 8'(st_a), 8'd0);
    chk("rst_irWrite", 8'(ir_a), 8'd0);
    chk("rst_flags", 8'({inv_a, bus_a}), 8'd0);

    // ADD, zero wait states
    rst_n = 1'b1;
    #1;
    chk("add_f_memReq", 8'(mreq_a), 8'd1);
    chk("add_f_irpc", 8'({ir_a, pcw_a, pcs_a}), 8'b1100);
    chk("add_f_aluFunc", 8'(af_a), 8'd0);
    tick();
    chk("add_d_state", 8'(st_a), 8'd1);
    chk("add_d_rfwe_alu", 8'({rfwe_a, af_a}), 8'd0);
    tick();
    chk("add_e_state", 8'(st_a), 8'd2);
    chk("add_e_rfwe", 8'(rfwe_a), 8'd0);
    tick();
    chk("add_wb_state", 8'(st_a), 8'd4);
    chk("add_wb_rf", 8'({rfwe_a, rfwa_a, rfds_a}), 8'b1100);
    chk("add_wb_aluFunc", 8'(af_a), 8'd2);
    tick();
    chk("add_done", 8'(st_a), 8'd0);

    // LW with three wait states in MEM
    opc = 6'h23;
    do_reset();
    tick();
    tick();
    memReady = 1'b0;
    tick();
    chk("lw_m1_state", 8'(st_a), 8'd3);
    chk("lw_m1_bus", 8'({mreq_a, mas_a, mw_a}), 8'b110);
    tick();
    tick();
    tick();
    memReady = 1'b1;
    #1;
    chk("lw_m4_bus", 8'({st_a, mreq_a, mas_a}), 8'b01111);
    tick();
    chk("lw_wb", 8'({st_a, rfwe_a, rfwa_a, rfds_a}), 8'b1001001);
    tick();
    chk("lw_done", 8'({st_a, bus_a}), 8'd0);

    run_branch("beq_taken", 6'h04, 1'b1, 1'b1);
    run_branch("beq_not", 6'h04, 1'b0, 1'b0);
    run_branch("bne_taken", 6'h05, 1'b0, 1'b1);
    run_branch("bne_not", 6'h05, 1'b1, 1'b0);

    // J: two cycles
    opc = 6'h02;
    do_reset();
    tick();
    chk("j_d", 8'({st_a, pcw_a, pcs_a}), 8'b001110);
    tick();
    chk("j_done", 8'(st_a), 8'd0);

    // SW: memWrite in MEM, back to FETCH after four cycles
    opc = 6'h2b;
    do_reset();
    tick();
    tick();
    tick();
    chk("sw_m", 8'({st_a, mreq_a, mas_a, mw_a, asrc_a}), 8'b0111111);
    tick();
    chk("sw_done", 8'(st_a), 8'd0);

    // LUI selects the immediate write path
    opc = 6'h0f;
    do_reset();
    tick();
    tick();
    tick();
    chk("lui_wb", 8'({st_a, rfwe_a, rfds_a}), 8'b100110);

    // ORI zero-extends its immediate
    opc = 6'h0d;
    do_reset();
    tick();
    tick();
    chk("ori_e", 8'({st_a, af_a, asrc_a, bx_a}), 8'b01000111);

    // LB: legal with sub-word ops, invalid without
    opc = 6'h20; func = 6'h00;
    do_reset();
    tick();
    tick();
    chk("lb_e_a", 8'({st_a, mds_a, mbe_a}), 8'b010100);
    chk("lb_exc_b", 8'({st_b, inv_b}), 8'b1011);
    tick();
    chk("lb_hold_b", 8'({st_b, inv_b, mreq_b, pcw_b}), 8'b101100);
    chk("lb_m_a", 8'({st_a, inv_a}), 8'b0110);
    excAck = 1'b1;
    tick();
    excAck = 1'b0;
    chk("lb_ack_b", 8'({st_b, inv_b}), 8'b0000);
    chk("lb_wb_a", 8'({st_a, inv_a, rfds_a}), 8'b100001);

    // Undefined R-type function
    opc = 6'h00; func = 6'h3f;
    do_reset();
    tick();
    tick();
    chk("rbad_exc", 8'({st_a, inv_a}), 8'b1011);
    tick();
    chk("rbad_hold", 8'({st_a, inv_a, pcw_a, ir_a}), 8'b101100);
    excAck = 1'b1;
    tick();
    excAck = 1'b0;
    chk("rbad_ack", 8'({st_a, inv_a}), 8'b0000);

    // Fetch timeout after four idle cycles
    func = 6'h20; memReady = 1'b0;
    do_reset();
    chk("to_c1", 8'({st_a, mreq_a}), 8'b0001);
    tick();
    tick();
    tick();
    chk("to_c4", 8'({st_a, ir_a, bus_a}), 8'b00000);
    tick();
    chk("to_exc", 8'({st_a, bus_a, ir_a, mreq_a}), 8'b101100);
    chk("to_nsw_still", 8'({st_b, bus_b}), 8'b0000);
    excAck = 1'b1;
    tick();
    excAck = 1'b0;
    chk("to_ack", 8'({st_a, bus_a}), 8'b0000);

    // Ready on the last allowed cycle wins over the timeout
    do_reset();
    tick();
    tick();
    tick();
    memReady = 1'b1;
    #1;
    chk("to_edge_ir", 8'({ir_a, pcw_a}), 8'b11);
    tick();
    chk("to_edge_dec", 8'({st_a, bus_a}), 8'b0010);

    // Reset during WB of ADDI
    opc = 6'h08;
    do_reset();
    tick();
    tick();
    tick();
    chk("addi_wb", 8'({st_a, rfwe_a, asrc_a, rfwa_a}), 8'b100110);
    rst_n = 1'b0;
    #1;
    chk("addi_rst", 8'({st_a, rfwe_a, mreq_a}), 8'b00000);
    rst_n = 1'b1;
    #1;
    chk("addi_rel", 8'({st_a, mreq_a, ir_a}), 8'b00011);
    tick();
    chk("addi_dec", 8'(st_a), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
